// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO, LSB first, frames sent back to back.
// Latency: a byte written into an empty FIFO while idle drives serial_out low one edge after the write.
// Backpressure: full is asserted at FIFO_DEPTH entries, and a write while full is silently dropped.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   data_in     byte to queue, sampled on the write edge only
//   wr_en       write strobe, accepted when full=0 before the edge
//   full        FIFO holds FIFO_DEPTH entries
//   fifo_count  number of entries currently queued
//   busy        frame in progress or bytes still queued
//   tx_done     one-cycle pulse in the last cycle of each stop bit
//   serial_out  UART line, idles high
module uart_tx #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    data_in,
   input  logic                          wr_en,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy,
   output logic                          tx_done,
   output logic                          serial_out
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = PW + 1;

   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
   localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);
   localparam logic [NW-1:0] CNT_ONE   = NW'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [NW-1:0] r_count;

   // transmitter state
   state_t        r_state;
   logic [CW-1:0] r_baud_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_serial;
   logic          r_tx_done;

   // next-state values
   state_t        w_state_nxt;
   logic [CW-1:0] w_baud_nxt;
   logic [2:0]    w_bit_idx_nxt;
   logic [7:0]    w_shift_nxt;
   logic          w_serial_nxt;
   logic          w_tx_done_nxt;
   logic          w_pop;

   logic          w_push;
   logic          w_fifo_empty;
   logic          w_baud_term;
   logic [7:0]    w_head;

   // full comes from the pre-edge count, so a write while full is dropped even if a pop happens on the same edge
   assign full         = (r_count == CNT_FULL);
   assign w_push       = wr_en & ~full;
   assign w_fifo_empty = (r_count == '0);
   assign w_head       = r_mem[r_rd_ptr];
   assign w_baud_term  = (r_baud_cnt == BAUD_LAST);

   assign fifo_count = r_count;
   assign busy       = (r_state != S_IDLE) || !w_fifo_empty;
   assign tx_done    = r_tx_done;
   assign serial_out = r_serial;

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // pointers wrap naturally because FIFO_DEPTH is a power of two
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Transmit FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_serial   <= 1'b1;
         r_tx_done  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_serial   <= w_serial_nxt;
         r_tx_done  <= w_tx_done_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Transmit FSM: next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_serial_nxt  = r_serial;
      w_tx_done_nxt = 1'b0;
      w_pop         = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_serial_nxt = 1'b1;
            if (!w_fifo_empty) begin
               w_pop        = 1'b1;
               w_shift_nxt  = w_head;
               w_baud_nxt   = '0;
               w_serial_nxt = 1'b0;
               w_state_nxt  = S_START;
            end
         end

         S_START: begin
            if (w_baud_term) begin
               w_baud_nxt    = '0;
               w_serial_nxt  = r_shift[0];
               w_bit_idx_nxt = 3'd0;
               w_state_nxt   = S_DATA;
            end else begin
               w_baud_nxt = r_baud_cnt + BAUD_ONE;
            end
         end

         S_DATA: begin
            if (w_baud_term) begin
               w_baud_nxt = '0;
               if (r_bit_idx == 3'd7) begin
                  w_serial_nxt = 1'b1;
                  w_state_nxt  = S_STOP;
               end else begin
                  // r_shift[1] is the bit that lands in position 0 after this shift
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_serial_nxt  = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud_cnt + BAUD_ONE;
            end
         end

         S_STOP: begin
            // set one edge early so the registered pulse covers the terminal-count cycle itself
            if (r_baud_cnt == BAUD_PRE) begin
               w_tx_done_nxt = 1'b1;
            end
            if (w_baud_term) begin
               w_baud_nxt = '0;
               if (!w_fifo_empty) begin
                  // chain straight into the next start bit: no idle cycle between frames
                  w_pop        = 1'b1;
                  w_shift_nxt  = w_head;
                  w_serial_nxt = 1'b0;
                  w_state_nxt  = S_START;
               end else begin
                  w_serial_nxt = 1'b1;
                  w_state_nxt  = S_IDLE;
               end
            end else begin
               w_baud_nxt = r_baud_cnt + BAUD_ONE;
            end
         end

         default: begin
            w_serial_nxt = 1'b1;
            w_state_nxt  = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx, one fast instance (16 clk/bit) and one at 9600 baud.
// Latency: checks the one-edge start latency, exact bit timing and back-to-back framing.
// Backpressure: checks full, dropped overflow writes and write/pop on the same edge.
module tb_uart_tx;

   localparam int CPB      = 16;
   localparam int CPB_SLOW = 10417;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // fast instance
   logic       rst_n   = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       wr_en   = 1'b0;
   logic       full;
   logic [2:0] fifo_count;
   logic       busy;
   logic       tx_done;
   logic       serial_out;

   // 9600 baud instance
   logic       rst_b  = 1'b0;
   logic [7:0] data_b = 8'h00;
   logic       wr_b   = 1'b0;
   logic       full_b;
   logic [2:0] cnt_b;
   logic       busy_b;
   logic       done_b;
   logic       ser_b;

   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut (
      .clk        (clk),
      .reset      (rst_n),
      .data_in    (data_in),
      .wr_en      (wr_en),
      .full       (full),
      .fifo_count (fifo_count),
      .busy       (busy),
      .tx_done    (tx_done),
      .serial_out (serial_out)
   );

   uart_tx #(.CLKS_PER_BIT(CPB_SLOW), .FIFO_DEPTH(4)) u_dut_baud (
      .clk        (clk),
      .reset      (rst_b),
      .data_in    (data_b),
      .wr_en      (wr_b),
      .full       (full_b),
      .fifo_count (cnt_b),
      .busy       (busy_b),
      .tx_done    (done_b),
      .serial_out (ser_b)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Line monitor for the fast instance: decodes frames at bit centres
   // ------------------------------------------------------------------
   logic       mon_prev  = 1'b1;
   int         mon_in    = 0;
   int         mon_start = 0;
   int         mon_off   = 0;
   int         mon_bad   = 0;
   logic [7:0] mon_sh    = 8'h00;
   logic [7:0] rx_q[$];
   int         st_q[$];
   int         td_q[$];

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         mon_in   = 0;
         mon_prev = 1'b1;
      end else begin
         if (tx_done) td_q.push_back(cyc);
         if (mon_in == 0) begin
            if (mon_prev && !serial_out) begin
               mon_in    = 1;
               mon_start = cyc;
               st_q.push_back(cyc);
            end
         end else begin
            mon_off = cyc - mon_start;
            if (mon_off == CPB / 2 && serial_out) mon_bad++;
            if ((mon_off % CPB) == CPB / 2 && mon_off > CPB && mon_off < 9 * CPB)
               mon_sh = {serial_out, mon_sh[7:1]};
            if (mon_off == 9 * CPB + CPB / 2) begin
               if (!serial_out) mon_bad++;
               rx_q.push_back(mon_sh);
               mon_in = 0;
            end
         end
         mon_prev = serial_out;
      end
   end

   function automatic int rx_at(input int i);
      return (i < rx_q.size()) ? int'(rx_q[i]) : -1;
   endfunction

   function automatic int st_at(input int i);
      return (i < st_q.size()) ? st_q[i] : -100000;
   endfunction

   function automatic int td_at(input int i);
      return (i < td_q.size()) ? td_q[i] : -100000;
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input int s);
      if (s == 0) return 1'b0;
      if (s == 9) return 1'b1;
      return b[s-1];
   endfunction

   task automatic clear_mon;
      rx_q.delete();
      st_q.delete();
      td_q.delete();
   endtask

   task automatic wait_idle(input int max_cyc, output int idle_cyc);
      int n;
      n = 0;
      while (busy && n < max_cyc) begin
         tick;
         n++;
      end
      check("idle_timeout", busy, 1'b0);
      idle_cyc = cyc;
   endtask

   // ------------------------------------------------------------------
   // Fast instance sequence
   // ------------------------------------------------------------------
   task automatic run_fast;
      int idle_cyc;
      int n;
      int n_low;
      int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};

      // reset state
      repeat (3) tick;
      check("rst_line", serial_out, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_count", fifo_count, 3'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      rst_n = 1'b1;
      repeat (2) tick;

      // single byte 0x55, exact per-cycle line and tx_done timing
      clear_mon();
      data_in = 8'h55;
      wr_en   = 1'b1;
      tick;
      wr_en   = 1'b0;
      data_in = 8'hAA;
      check("sb_line_write_edge", serial_out, 1'b1);
      check("sb_count", fifo_count, 3'd1);
      check("sb_busy", busy, 1'b1);
      for (int i = 0; i < 10 * CPB; i++) begin
         tick;
         check($sformatf("sb_line_c%0d", i), serial_out, frame_bit(8'h55, i / CPB));
         check($sformatf("sb_done_c%0d", i), tx_done, (i == 10 * CPB - 1));
      end
      check("sb_busy_last", busy, 1'b1);
      tick;
      check("sb_busy_fall", busy, 1'b0);
      check("sb_line_idle", serial_out, 1'b1);
      check("sb_done_low", tx_done, 1'b0);
      check("sb_rx_n", rx_q.size(), 1);
      check("sb_rx0", rx_at(0), 32'h55);

      // back-to-back frames
      clear_mon();
      wr_en = 1'b1;
      data_in = 8'h00; tick;
      data_in = 8'hFF; tick;
      data_in = 8'h3C; tick;
      wr_en = 1'b0;
      wait_idle(700, idle_cyc);
      check("b2b_rx_n", rx_q.size(), 3);
      check("b2b_rx0", rx_at(0), 32'h00);
      check("b2b_rx1", rx_at(1), 32'hFF);
      check("b2b_rx2", rx_at(2), 32'h3C);
      check("b2b_gap1", st_at(1) - st_at(0), 10 * CPB);
      check("b2b_gap2", st_at(2) - st_at(1), 10 * CPB);
      check("b2b_done_n", td_q.size(), 3);
      check("b2b_done_first", td_at(0) - st_at(0), 10 * CPB - 1);
      check("b2b_done_gap1", td_at(1) - td_at(0), 10 * CPB);
      check("b2b_done_gap2", td_at(2) - td_at(1), 10 * CPB);
      check("b2b_total", idle_cyc - st_at(0), 30 * CPB);

      // overflow: 0x06 must be dropped
      clear_mon();
      for (int k = 0; k < 6; k++) begin
         data_in = 8'(k + 1);
         wr_en   = 1'b1;
         tick;
         check($sformatf("ovf_count_w%0d", k), fifo_count, exp_cnt[k]);
         check($sformatf("ovf_full_w%0d", k), full, (exp_cnt[k] == 4));
      end
      wr_en = 1'b0;
      wait_idle(1000, idle_cyc);
      check("ovf_rx_n", rx_q.size(), 5);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("ovf_rx%0d", k), rx_at(k), k + 1);
      end

      // write on the STOP terminal-count edge while a pop happens
      clear_mon();
      wr_en = 1'b1;
      data_in = 8'hA1; tick;
      data_in = 8'hB2; tick;
      wr_en = 1'b0;
      check("sim_count_queued", fifo_count, 3'd1);
      n = 0;
      while (!tx_done && n < 400) begin
         tick;
         n++;
      end
      check("sim_done_seen", tx_done, 1'b1);
      check("sim_count_pre", fifo_count, 3'd1);
      data_in = 8'hC3;
      wr_en   = 1'b1;
      tick;
      wr_en   = 1'b0;
      check("sim_count_post", fifo_count, 3'd1);
      check("sim_restart_line", serial_out, 1'b0);
      wait_idle(700, idle_cyc);
      check("sim_rx_n", rx_q.size(), 3);
      check("sim_rx0", rx_at(0), 32'hA1);
      check("sim_rx1", rx_at(1), 32'hB2);
      check("sim_rx2", rx_at(2), 32'hC3);

      // asynchronous reset during bit 3 of 0xA5 with a byte still queued
      clear_mon();
      wr_en = 1'b1;
      data_in = 8'hA5; tick;
      data_in = 8'h11; tick;
      wr_en = 1'b0;
      repeat (4 * CPB + 6) tick;
      check("mid_line_bit3", serial_out, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_line", serial_out, 1'b1);
      check("mid_rst_count", fifo_count, 3'd0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_full", full, 1'b0);
      repeat (3) tick;
      rst_n = 1'b1;
      n_low = 0;
      for (int i = 0; i < 200; i++) begin
         tick;
         if (serial_out !== 1'b1) n_low++;
      end
      check("mid_quiet_line", n_low, 0);
      check("mid_quiet_busy", busy, 1'b0);
      check("mid_quiet_count", fifo_count, 3'd0);
      check("mid_quiet_rx", rx_q.size(), 0);
      check("mon_framing", mon_bad, 0);
   endtask

   // ------------------------------------------------------------------
   // 9600 baud instance: 0x96 is 0,1,1,0,1,... LSB first, so the line
   // falls at slot 0, rises at slot 2, falls at slot 4, rises at slot 5
   // ------------------------------------------------------------------
   task automatic run_baud;
      int   t[4] = '{0, 0, 0, 0};
      int   nt;
      int   n;
      int   wcyc;
      logic prev;

      repeat (2) tick;
      check("baud_rst_line", ser_b, 1'b1);
      rst_b = 1'b1;
      tick;
      data_b = 8'h96;
      wr_b   = 1'b1;
      tick;
      wr_b   = 1'b0;
      wcyc   = cyc;
      prev   = ser_b;
      nt     = 0;
      n      = 0;
      while (nt < 4 && n < 60000) begin
         tick;
         n++;
         if (ser_b !== prev) begin
            t[nt] = cyc;
            nt++;
            prev = ser_b;
         end
      end
      check("baud_edges", nt, 4);
      check("baud_start_latency", t[0] - wcyc, 1);
      check("baud_start_b0", t[1] - t[0], 2 * CPB_SLOW);
      check("baud_b1_b2", t[2] - t[1], 2 * CPB_SLOW);
      check("baud_b3", t[3] - t[2], CPB_SLOW);
      check("baud_busy", busy_b, 1'b1);
   endtask

   initial begin
      fork
         run_fast();
         run_baud();
      join
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; the transmit-direction partner of the board-level UART receiver on the RsRx/RsTx pins.
- Bytes pushed by the core are buffered in a small FIFO and shifted out LSB-first on serial_out, with no idle gap between queued frames.
- Sits at top level next to the receiver. Drives RsTx for status and echo from the pong/VGA designs.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); legal range 4..65535.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  8  byte to queue.
- wr_en  input  1  write strobe; data_in is captured on a rising edge where wr_en=1 and full=0.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued.
- busy  output  1  FSM not IDLE, or FIFO non-empty.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.
- serial_out  output  1  UART line; idles high.

Behaviour:
- **Reset** (reset=0, asynchronous):
  - serial_out=1, full=0, fifo_count=0, busy=0, tx_done=0.
  - FSM=IDLE; FIFO pointers, baud counter and bit index cleared.
  - Applies immediately, including mid-frame; the partial frame is abandoned and queued bytes are discarded.
- **Registers**: all outputs are registered. full and busy are derived from registered state (fifo_count, FSM).
- **FIFO**:
  - Circular buffer with read/write pointers and a count.
  - Write while full is ignored: no pointer, count or data change.
  - Write and pop on the same edge while not full: count unchanged, both pointers advance.
  - Write while full coinciding with a pop: write still ignored, because full is evaluated from the pre-edge state.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states**: IDLE, START, DATA, STOP.
- **IDLE**:
  - serial_out=1.
  - If FIFO non-empty: pop the head into an 8-bit shift register, clear the baud counter, set serial_out=0, go to START.
  - A byte written at edge N into an empty FIFO with FSM idle drives serial_out low after edge N+1.
- **START**:
  - Hold serial_out=0 for CLKS_PER_BIT cycles; the baud counter counts 0..CLKS_PER_BIT-1.
  - On terminal count: output shift[0], bit index=0, go to DATA.
- **DATA**:
  - Each bit is held CLKS_PER_BIT cycles.
  - On terminal count with bit index<7: shift right, increment bit index, output the next bit.
  - At bit index 7: set serial_out=1, go to STOP.
- **STOP**:
  - Hold serial_out=1 for CLKS_PER_BIT cycles.
  - On terminal count: pulse tx_done=1 for exactly that one cycle.
  - Then, if FIFO non-empty, pop and go straight to START (serial_out=0 on the same edge, zero idle time); otherwise go to IDLE.
- **Frame timing**:
  - Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the serial_out falling edge to the earliest possible next start edge.
  - Bits are sent LSB first.
- **data_in stability**: data_in need only be valid on the write edge; the FIFO holds the copy.
- **busy**: deasserts on the edge the FSM enters IDLE with the FIFO empty.
- **Width rules**:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide and compares against CLKS_PER_BIT-1.
  - Bit index is 3 bits.
  - fifo_count never exceeds FIFO_DEPTH.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4 unless noted):
- **Reset mid-frame**: reset low for 3 cycles during bit 3 of 0xA5 -> serial_out=1 asynchronously, fifo_count=0, busy=0; no further transitions until the next write.
- **Single byte**: write 0x55 once -> serial_out low one edge after the write; line sequence 0,1,0,1,0,1,0,1,0,1, each held exactly 16 cycles; tx_done pulses once at cycle 160 of the frame; busy falls the next cycle.
- **Back-to-back**: write 0x00, 0xFF, 0x3C on consecutive cycles -> three contiguous frames totalling 480 cycles, no extra high cycle between stop and start; tx_done pulses 3 times at 160-cycle spacing; decoded bytes 0x00, 0xFF, 0x3C in order.
- **Overflow**: write 0x01..0x06 on 6 consecutive cycles -> 0x01 popped at IDLE, 0x02..0x05 fill the FIFO, full=1, 0x06 dropped; output bytes exactly 0x01..0x05.
- **Simultaneous write/pop**: with FIFO non-full, assert wr_en on the STOP terminal-count edge -> fifo_count unchanged across that edge, new byte sent after the queued ones.
- **Baud accuracy**: CLKS_PER_BIT=10417 -> measured bit period exactly 10417 clk cycles for every bit of 0x96.
